// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the uart command engine.
// Holds the engine state enum, host-protocol opcodes/response bytes and
// command-length constants used by the parser.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR   = 8'h57;  // 'W' addr data
  localparam logic [7:0] CMD_RD   = 8'h52;  // 'R' addr
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  // byte_idx counts captured bytes of the current command (0..3).
  localparam int               IDX_W   = 2;
  localparam logic [IDX_W-1:0] LEN_BAD = 2'd0;
  localparam logic [IDX_W-1:0] LEN_RD  = 2'd2;
  localparam logic [IDX_W-1:0] LEN_WR  = 2'd3;

  typedef enum logic [3:0] {
    IDLE, RX_ULD, RX_WAIT, RX_CAP, DISPATCH, MEM_WR, MEM_RD, MEM_RD_WAIT,
    TX_LD, TX_HOLD, TX_WAIT
  } state_t;

  // Total command length in bytes including the opcode; 0 = unknown opcode.
  function automatic logic [IDX_W-1:0] cmd_len(input logic [7:0] op);
    if (op == CMD_WR)      return LEN_WR;
    else if (op == CMD_RD) return LEN_RD;
    else                   return LEN_BAD;
  endfunction

endpackage

// File: rtl/uart_cmd_engine_if.sv
// uart_cmd_engine_if: bundles the uart rx/tx handshake, the block-RAM port
// and the status outputs of the command engine.
// master = engine side (drives strobes, tx byte, memory port, status); slave = environment.
interface uart_cmd_engine_if;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       uld_rx_data;
  logic       tx_empty;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic [7:0] err_count;

  modport master (
    input  rx_empty, rx_data, tx_empty, mem_rdata,
    output uld_rx_data, ld_tx_data, tx_data, mem_en, mem_we, mem_addr, mem_wdata,
           busy, err_count
  );

  modport slave (
    output rx_empty, rx_data, tx_empty, mem_rdata,
    input  uld_rx_data, ld_tx_data, tx_data, mem_en, mem_we, mem_addr, mem_wdata,
           busy, err_count
  );
endinterface

// File: rtl/uart_tx_loader.sv
// uart_tx_loader: hands one response byte to the uart transmitter and waits
// until it has been shifted out. Ports: load/tx_byte (start request),
// tx_empty (uart ready), ld_tx_data/tx_data (to uart), done (byte fully sent).
module uart_tx_loader
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       tx_empty,
  output logic       ld_tx_data,
  output logic [7:0] tx_data,
  output logic       done
);

  state_t state, state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ld_tx_data <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      state      <= state_next;
      // Strobe lands in the TX_HOLD cycle; tx_empty only drops after the
      // uart samples it, which is why TX_WAIT starts one cycle later.
      ld_tx_data <= (state == TX_LD) && tx_empty;
      if (load) tx_data <= tx_byte;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:    if (load) state_next = TX_LD;
      TX_LD:   if (tx_empty) state_next = TX_HOLD;
      TX_HOLD: state_next = TX_WAIT;
      TX_WAIT: if (tx_empty) begin
        state_next = IDLE;
        done       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: parses W/R host commands from the uart rx path, performs one
// BRAM access and returns ACK, read data or NAK. Ports: clk, reset (async high),
// bus (uart rx/tx handshake, BRAM port, busy, err_count).
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                clk,
  input logic                reset,
  uart_cmd_engine_if.master  bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [7:0]       opcode, addr, wdata;
  logic [IDX_W-1:0] byte_idx;
  logic [CNT_W-1:0] tmo_cnt;
  logic             load, nak, tx_done;
  logic [7:0]       load_byte;

  uart_tx_loader u_tx (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .tx_byte    (load_byte),
    .tx_empty   (bus.tx_empty),
    .ld_tx_data (bus.ld_tx_data),
    .tx_data    (bus.tx_data),
    .done       (tx_done)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_byte  = ACK_BYTE;
    nak        = 1'b0;
    case (state)
      IDLE:    if (!bus.rx_empty) state_next = RX_ULD;
      RX_ULD:  state_next = RX_WAIT;
      RX_WAIT: state_next = RX_CAP;
      RX_CAP:  state_next = DISPATCH;
      // DISPATCH doubles as the inter-byte wait: busy stays high and the
      // timeout counter runs until the next byte or expiry.
      DISPATCH: begin
        if (cmd_len(opcode) == LEN_BAD)       nak = 1'b1;
        else if (byte_idx == cmd_len(opcode)) state_next = (opcode == CMD_WR) ? MEM_WR : MEM_RD;
        else if (!bus.rx_empty)               state_next = RX_ULD;
        else if (tmo_cnt == CNT_LAST)         nak = 1'b1;
      end
      MEM_WR:  load = 1'b1;
      MEM_RD:  state_next = MEM_RD_WAIT;
      MEM_RD_WAIT: begin
        load      = 1'b1;
        load_byte = bus.mem_rdata;
      end
      TX_LD:   if (tx_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (nak) begin
      load      = 1'b1;
      load_byte = NAK_BYTE;
    end
    if (load) state_next = TX_LD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      opcode          <= 8'h00;
      addr            <= 8'h00;
      wdata           <= 8'h00;
      byte_idx        <= '0;
      tmo_cnt         <= '0;
      bus.uld_rx_data <= 1'b0;
      bus.mem_en      <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= 8'h00;
      bus.mem_wdata   <= 8'h00;
      bus.busy        <= 1'b0;
      bus.err_count   <= 8'h00;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        byte_idx <= '0;
        tmo_cnt  <= '0;
      end else if (state == RX_CAP) begin
        if (byte_idx == 2'd0)      opcode <= bus.rx_data;
        else if (byte_idx == 2'd1) addr   <= bus.rx_data;
        else                       wdata  <= bus.rx_data;
        byte_idx <= byte_idx + 2'd1;
        tmo_cnt  <= '0;
      end else if (state == DISPATCH && state_next == DISPATCH) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      // Outputs are registered from the next state so each strobe is
      // aligned with the state it belongs to.
      bus.uld_rx_data <= (state_next == RX_ULD);
      bus.mem_en      <= (state_next == MEM_WR) || (state_next == MEM_RD);
      bus.mem_we      <= (state_next == MEM_WR);
      if ((state_next == MEM_WR) || (state_next == MEM_RD)) bus.mem_addr <= addr;
      if (state_next == MEM_WR) bus.mem_wdata <= wdata;
      bus.busy <= (state_next != IDLE);
      if (nak && (bus.err_count != 8'hFF)) bus.err_count <= bus.err_count + 8'd1;
    end
  end

endmodule
